// File: rtl/tpu_package.sv
// tpu_package -- shared types and constants for the matmul sequencer slice.
//   seq_state_t          : sequencer FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   MAC_OP_NOP           : opcode driven to the MAC array when nothing is issued
//   MAC_PIPE_LAT_DEFAULT : default read-issue to result-write latency in cycles
//   ADDR_W/DIM_W/CNT_W   : unified-buffer address, dimension and count widths
package tpu_package;

  localparam int ADDR_W = 12;
  localparam int DIM_W  = 7;
  localparam int CNT_W  = 14;  // holds up to 127*127 transfers
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] MAC_OP_NOP = 3'b000;
  localparam int MAC_PIPE_LAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line -- fixed-latency valid pipeline that turns each issued
// unified-buffer read into the matching result-write strobe.
//   clk_i, rst_i : clock and synchronous active-high reset (clears the line)
//   en           : a read is issued this cycle
//   stall        : freeze the line; valid is forced low while stalled
//   valid        : a read issued DEPTH non-stalled cycles ago retires now
//   empty        : nothing is in flight behind the entry leaving this cycle,
//                  so once this cycle advances the line holds no entries
module valid_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en,
  input  logic stall,
  output logic valid,
  output logic empty
);

  localparam logic [DEPTH-1:0] TOP_BIT = DEPTH'(1) << (DEPTH - 1);

  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else if (!stall) begin
      pipe_q <= (pipe_q << 1) | DEPTH'(en);
    end
  end

  assign valid = pipe_q[DEPTH-1] & ~stall;
  // The output stage is excluded so the sequencer can leave DRAIN on the
  // same cycle the final write retires.
  assign empty = ((pipe_q & ~TOP_BIT) == '0);

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer -- steps a decoded MAC instruction over the unified buffer:
// issues V*ITER consecutive reads, and MAC_PIPE_LAT non-stalled cycles after
// each read issues the matching result write, then pulses done_o.
//
// Build option: define MATMUL_SEQ_PERF_CNT_EN to enable the run-cycle counter
// on perf_cycles_o; otherwise perf_cycles_o is tied to zero.
//
// Ports:
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   instr_valid_i / instr_ready_o : instruction handshake (see below)
//   MAC_op_i, V_dim_i, ITER_dim_i : decoded opcode, vector length, iterations
//   ub_rd_start_i, ub_wr_start_i  : unified-buffer start addresses
//   stall_i                       : freeze all sequencing state
//   ub_rd_en_o, ub_rd_addr_o      : unified-buffer read request
//   ub_wr_en_o, ub_wr_addr_o      : unified-buffer write request
//   MAC_op_o                      : opcode to the MAC array (NOP when idle)
//   busy_o, done_o                : operation in progress / one-cycle finish
//   perf_cycles_o                 : non-stalled RUN+DRAIN cycle count
//   state_dbg_o                   : current FSM state, for observation only
//
// Handshake: an instruction is accepted on a cycle where instr_valid_i and
// instr_ready_o are both high. instr_ready_o is high only in IDLE without
// stall; the producer holds instr_valid_i and the fields until accepted.
module matmul_sequencer
  import tpu_package::*;
#(
  parameter int MAC_PIPE_LAT = MAC_PIPE_LAT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [2:0]  MAC_op_i,
  input  logic [6:0]  V_dim_i,
  input  logic [6:0]  ITER_dim_i,
  input  logic [11:0] ub_rd_start_i,
  input  logic [11:0] ub_wr_start_i,
  input  logic        stall_i,
  output logic        ub_rd_en_o,
  output logic [11:0] ub_rd_addr_o,
  output logic        ub_wr_en_o,
  output logic [11:0] ub_wr_addr_o,
  output logic [2:0]  MAC_op_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] perf_cycles_o,
  output logic [1:0]  state_dbg_o
);

  seq_state_t state_q, state_d;

  logic [OP_W-1:0]   op_q;
  logic [DIM_W-1:0]  v_dim_q, it_dim_q;
  logic [DIM_W-1:0]  v_cnt_q, it_cnt_q;
  logic [ADDR_W-1:0] rd_start_q, wr_start_q;
  logic [CNT_W-1:0]  rd_cnt_q, wr_cnt_q;

  logic accept;
  logic zero_dim;
  logic v_last;
  logic last_read;
  logic dl_valid;
  logic dl_empty;
  logic cnt_unused;

  assign instr_ready_o = (state_q == IDLE) && !stall_i;
  assign accept        = instr_ready_o && instr_valid_i;
  assign zero_dim      = (V_dim_i == '0) || (ITER_dim_i == '0);
  assign v_last        = (v_cnt_q == v_dim_q - 7'd1);
  assign last_read     = v_last && (it_cnt_q == it_dim_q - 7'd1);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ub_rd_en_o = 1'b0;
    MAC_op_o   = MAC_OP_NOP;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        // Empty instructions skip straight to DONE so the caller still
        // sees exactly one done_o pulse.
        if (accept) state_d = zero_dim ? DONE : RUN;
      end
      RUN: begin
        if (!stall_i) begin
          ub_rd_en_o = 1'b1;
          MAC_op_o   = op_q;
          if (last_read) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!stall_i && dl_empty) state_d = DONE;
      end
      DONE: begin
        if (!stall_i) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_dbg_o = state_q;

  // ------------------------------------------------------- datapath regs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q       <= MAC_OP_NOP;
      v_dim_q    <= '0;
      it_dim_q   <= '0;
      v_cnt_q    <= '0;
      it_cnt_q   <= '0;
      rd_start_q <= '0;
      wr_start_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else if (accept) begin
      op_q       <= MAC_op_i;
      v_dim_q    <= V_dim_i;
      it_dim_q   <= ITER_dim_i;
      rd_start_q <= ub_rd_start_i;
      wr_start_q <= ub_wr_start_i;
      v_cnt_q    <= '0;
      it_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      if (ub_rd_en_o) begin
        rd_cnt_q <= rd_cnt_q + 14'd1;
        if (v_last) begin
          v_cnt_q  <= '0;
          it_cnt_q <= it_cnt_q + 7'd1;
        end else begin
          v_cnt_q  <= v_cnt_q + 7'd1;
        end
      end
      if (ub_wr_en_o) wr_cnt_q <= wr_cnt_q + 14'd1;
    end
  end

  // Address generation wraps at 4 KiB; only the low count bits matter here.
  assign ub_rd_addr_o = rd_start_q + rd_cnt_q[ADDR_W-1:0];
  assign ub_wr_addr_o = wr_start_q + wr_cnt_q[ADDR_W-1:0];
  assign cnt_unused   = ^{rd_cnt_q[CNT_W-1:ADDR_W], wr_cnt_q[CNT_W-1:ADDR_W]};

  // --------------------------------------------------- write-valid delay
  valid_delay_line #(
    .DEPTH (MAC_PIPE_LAT)
  ) u_wr_delay (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (ub_rd_en_o),
    .stall (stall_i),
    .valid (dl_valid),
    .empty (dl_empty)
  );

  assign ub_wr_en_o = dl_valid;

  // ------------------------------------------------- performance counter
`ifdef MATMUL_SEQ_PERF_CNT_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || accept) begin
      perf_q <= '0;
    end else if (!stall_i && (state_q == RUN || state_q == DRAIN) &&
                 perf_q != 16'hFFFF) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer -- directed and randomized checks of matmul_sequencer
// against a cycle-indexed reference: for an instruction of N = V*ITER
// transfers, counting only non-stalled cycles after the handshake, reads
// occur on cycles 0..N-1, writes on LAT..LAT+N-1 and done on N+LAT
// (cycle 0 when N == 0).
module tb_matmul_sequencer;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [2:0]  MAC_op_i;
  logic [6:0]  V_dim_i;
  logic [6:0]  ITER_dim_i;
  logic [11:0] ub_rd_start_i;
  logic [11:0] ub_wr_start_i;
  logic        stall_i;
  logic        ub_rd_en_o;
  logic [11:0] ub_rd_addr_o;
  logic        ub_wr_en_o;
  logic [11:0] ub_wr_addr_o;
  logic [2:0]  MAC_op_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] perf_cycles_o;
  logic [1:0]  state_dbg_o;

  int total = 0;
  int bad   = 0;

  // Instruction that is held on the bus while the current one runs.
  int          nxt_v, nxt_it;
  logic [11:0] nxt_rs, nxt_ws;
  logic [2:0]  nxt_op;

  logic [11:0] exp_rd_q[$];
  logic [11:0] exp_wr_q[$];

  // ---------------------------------------------------- clock and reset
  always #5 clk = ~clk;

  matmul_sequencer #(.MAC_PIPE_LAT(LAT)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .MAC_op_i      (MAC_op_i),
    .V_dim_i       (V_dim_i),
    .ITER_dim_i    (ITER_dim_i),
    .ub_rd_start_i (ub_rd_start_i),
    .ub_wr_start_i (ub_wr_start_i),
    .stall_i       (stall_i),
    .ub_rd_en_o    (ub_rd_en_o),
    .ub_rd_addr_o  (ub_rd_addr_o),
    .ub_wr_en_o    (ub_wr_en_o),
    .ub_wr_addr_o  (ub_wr_addr_o),
    .MAC_op_o      (MAC_op_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .perf_cycles_o (perf_cycles_o),
    .state_dbg_o   (state_dbg_o)
  );

  // ---------------------------------------------------------- scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_perf(input int n);
    int r;
    r = (n == 0) ? 0 : n + LAT;
`ifndef MATMUL_SEQ_PERF_CNT_EN
    r = 0;
`endif
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},   32'(instr_ready_o), 32'(1));
    chk({tag, "_rd_en"},   32'(ub_rd_en_o),    32'(0));
    chk({tag, "_wr_en"},   32'(ub_wr_en_o),    32'(0));
    chk({tag, "_busy"},    32'(busy_o),        32'(0));
    chk({tag, "_done"},    32'(done_o),        32'(0));
    chk({tag, "_mac_op"},  32'(MAC_op_o),      32'(0));
    chk({tag, "_rd_addr"}, 32'(ub_rd_addr_o),  32'(0));
    chk({tag, "_wr_addr"}, 32'(ub_wr_addr_o),  32'(0));
    chk({tag, "_perf"},    32'(perf_cycles_o), 32'(0));
  endtask

  // ------------------------------------------------------------- driver
  // abort_ns >= 0 asserts reset right after non-stalled cycle abort_ns.
  task automatic run_op(input int v, input int it, input logic [11:0] rs,
                        input logic [11:0] ws, input logic [2:0] op,
                        input int stall_at, input int stall_len,
                        input bit rand_stall, input bit hold_next,
                        input bit expect_immediate, input int abort_ns);
    int n, done_ns, ns, cyc, waited, stalled_cnt, issued, written, budget;
    bit stall, done_seen, aborted;
    logic [11:0] a;
    n       = v * it;
    done_ns = (n == 0) ? 0 : n + LAT;
    exp_rd_q.delete();
    exp_wr_q.delete();
    for (int k = 0; k < n; k++) begin
      exp_rd_q.push_back(rs + 12'(k));
      exp_wr_q.push_back(ws + 12'(k));
    end

    @(posedge clk); #1;
    instr_valid_i = 1'b1;
    MAC_op_i      = op;
    V_dim_i       = 7'(v);
    ITER_dim_i    = 7'(it);
    ub_rd_start_i = rs;
    ub_wr_start_i = ws;
    stall_i       = 1'b0;
    #1;
    waited = 0;
    while (!instr_ready_o && waited < 300) begin
      @(posedge clk); #2;
      waited++;
    end
    chk("hs_ready", 32'(instr_ready_o), 32'(1));
    if (expect_immediate) chk("hs_first_idle", 32'(waited), 32'(0));

    ns = 0; cyc = 0; stalled_cnt = 0; done_seen = 0; aborted = 0;
    budget = 4 * (done_ns + 1) + 40;
    while (!done_seen && !aborted && cyc < budget) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        if (hold_next) begin
          MAC_op_i      = nxt_op;
          V_dim_i       = 7'(nxt_v);
          ITER_dim_i    = 7'(nxt_it);
          ub_rd_start_i = nxt_rs;
          ub_wr_start_i = nxt_ws;
        end else begin
          instr_valid_i = 1'b0;
        end
      end
      if (rand_stall) stall = (ns >= 1 && ns < done_ns && $urandom_range(0, 3) == 0);
      else            stall = (stall_len > 0 && ns == stall_at && stalled_cnt < stall_len);
      stall_i = stall;
      #1;
      issued  = (ns < n) ? ns : n;
      written = (ns <= LAT) ? 0 : ((ns - LAT < n) ? ns - LAT : n);

      chk("busy",       32'(busy_o),        32'(1));
      chk("ready_busy", 32'(instr_ready_o), 32'(0));
      chk("done",       32'(done_o),        32'(!stall && ns == done_ns));
      if (stall) begin
        chk("stall_rd_en",   32'(ub_rd_en_o),   32'(0));
        chk("stall_wr_en",   32'(ub_wr_en_o),   32'(0));
        chk("stall_mac_op",  32'(MAC_op_o),     32'(0));
        chk("stall_rd_addr", 32'(ub_rd_addr_o), 32'(rs + 12'(issued)));
        chk("stall_wr_addr", 32'(ub_wr_addr_o), 32'(ws + 12'(written)));
        stalled_cnt++;
      end else begin
        chk("rd_en",  32'(ub_rd_en_o), 32'(ns < n));
        chk("wr_en",  32'(ub_wr_en_o), 32'(ns >= LAT && ns < n + LAT));
        chk("mac_op", 32'(MAC_op_o),   32'((ns < n) ? op : 3'd0));
        if (ub_rd_en_o) begin
          chk("rd_q_avail", 32'(exp_rd_q.size() != 0), 32'(1));
          if (exp_rd_q.size() != 0) begin
            a = exp_rd_q.pop_front();
            chk("rd_addr", 32'(ub_rd_addr_o), 32'(a));
          end
        end
        if (ub_wr_en_o) begin
          chk("wr_q_avail", 32'(exp_wr_q.size() != 0), 32'(1));
          if (exp_wr_q.size() != 0) begin
            a = exp_wr_q.pop_front();
            chk("wr_addr", 32'(ub_wr_addr_o), 32'(a));
          end
        end
        if (ns == done_ns) begin
          chk("perf", 32'(perf_cycles_o), 32'(exp_perf(n)));
          done_seen = 1;
        end
        if (abort_ns >= 0 && ns == abort_ns) begin
          rst_i = 1'b1;
          @(posedge clk); #1;
          rst_i = 1'b0;
          #1;
          check_reset_outputs("abort");
          for (int k = 0; k < 8; k++) begin
            @(posedge clk); #2;
            chk("abort_no_done", 32'(done_o), 32'(0));
            chk("abort_idle",    32'(busy_o), 32'(0));
          end
          aborted = 1;
        end
        ns++;
      end
      cyc++;
    end
    stall_i = 1'b0;

    if (!aborted) begin
      chk("completed", 32'(done_seen), 32'(1));
      chk("rd_q_empty", 32'(exp_rd_q.size()), 32'(0));
      chk("wr_q_empty", 32'(exp_wr_q.size()), 32'(0));
      if (!rand_stall && stall_len > 0 && done_seen)
        chk("stall_latency", 32'(cyc - 1), 32'(done_ns + stall_len));
      if (!hold_next) begin
        @(posedge clk); #2;
        chk("post_busy",  32'(busy_o),        32'(0));
        chk("post_done",  32'(done_o),        32'(0));
        chk("post_ready", 32'(instr_ready_o), 32'(1));
        chk("post_rd_en", 32'(ub_rd_en_o),    32'(0));
        chk("post_wr_en", 32'(ub_wr_en_o),    32'(0));
      end
    end
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    rst_i = 1'b1; instr_valid_i = 1'b0; stall_i = 1'b0;
    MAC_op_i = '0; V_dim_i = '0; ITER_dim_i = '0;
    ub_rd_start_i = '0; ub_wr_start_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    #1;
    check_reset_outputs("reset");

    // Basic 3x2 run: reads 0x010..0x015, writes 0x100..0x105.
    run_op(3, 2, 12'h010, 12'h100, 3'b101, 0, 0, 0, 0, 0, -1);
    // Zero-length instruction completes immediately.
    run_op(0, 5, 12'h020, 12'h200, 3'b011, 0, 0, 0, 0, 0, -1);
    // Read and write address wrap at 4 KiB.
    run_op(4, 1, 12'hFFE, 12'hFFD, 3'b010, 0, 0, 0, 0, 0, -1);
    // Three-cycle stall mid-RUN.
    run_op(4, 1, 12'h040, 12'h400, 3'b110, 2, 3, 0, 0, 0, -1);
    // Next instruction held while busy, accepted on the first IDLE cycle.
    nxt_v = 2; nxt_it = 2; nxt_rs = 12'h300; nxt_ws = 12'h700; nxt_op = 3'b001;
    run_op(3, 2, 12'h050, 12'h500, 3'b100, 0, 0, 0, 1, 0, -1);
    run_op(nxt_v, nxt_it, nxt_rs, nxt_ws, nxt_op, 0, 0, 0, 0, 1, -1);
    // Reset during DRAIN, then a normal instruction.
    run_op(3, 2, 12'h060, 12'h600, 3'b111, 0, 0, 0, 0, 0, 7);
    run_op(2, 3, 12'h070, 12'h7F0, 3'b011, 0, 0, 0, 0, 0, -1);
    // Random instructions with random stalls.
    for (int i = 0; i < 6; i++) begin
      run_op(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
             12'($urandom), 12'($urandom), 3'($urandom_range(1, 7)),
             0, 0, 1, 0, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter MAC_PIPE_LAT, default 4, meaning cycles from a unified-buffer read issue to the matching result write.
REQ-002 SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port instr_valid_i  in  1  decoded instruction present.
REQ-005 SHALL have port instr_ready_o  out  1  sequencer accepts an instruction this cycle.
REQ-006 SHALL have port MAC_op_i  in  3  decoded MAC opcode.
REQ-007 SHALL have ports V_dim_i, ITER_dim_i  in  7 each  decoded vector length and iteration count.
REQ-008 SHALL have ports ub_rd_start_i, ub_wr_start_i  in  12 each  unified-buffer start addresses.
REQ-009 SHALL have port stall_i  in  1  freeze all sequencing.
REQ-010 SHALL have ports ub_rd_en_o  out  1 and ub_rd_addr_o  out  12  unified-buffer read request.
REQ-011 SHALL have ports ub_wr_en_o  out  1 and ub_wr_addr_o  out  12  unified-buffer write request.
REQ-012 SHALL have port MAC_op_o  out  3  opcode driven to the array; 3'b000 = NOP.
REQ-013 SHALL have ports busy_o  out  1 and done_o  out  1  (done_o is a one-cycle pulse).
REQ-014 SHALL have port perf_cycles_o  out  16  run-cycle count (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-016 instr_ready_o SHALL be 1 only in IDLE; handshake fires when instr_valid_i && instr_ready_o.
REQ-017 On handshake SHALL latch all instruction fields, clear counters v_cnt, it_cnt, go to RUN; busy_o = 1 from the next cycle until DONE exits.
REQ-018 Handshake with V_dim_i == 0 or ITER_dim_i == 0 SHALL go directly to DONE with no reads or writes.
REQ-019 In RUN with stall_i = 0: ub_rd_en_o = 1, ub_rd_addr_o = rd_start + issued-read count (mod 4096), MAC_op_o = latched op.
REQ-020 v_cnt SHALL count 0..V-1; at V-1 it wraps to 0 and it_cnt increments; after v_cnt = V-1 with it_cnt = ITER-1, SHALL go to DRAIN; total reads = V*ITER.
REQ-021 Each issued read SHALL produce ub_wr_en_o = 1 exactly MAC_PIPE_LAT non-stalled cycles later; ub_wr_addr_o = wr_start + completed-write count (mod 4096).
REQ-022 DRAIN SHALL drive MAC_op_o = NOP, ub_rd_en_o = 0, and go to DONE once the delay line is empty.
REQ-023 DONE SHALL last one cycle with done_o = 1, then return to IDLE.
REQ-024 stall_i = 1 SHALL hold every counter, the delay line, and FSM state; ub_rd_en_o = ub_wr_en_o = 0 and MAC_op_o = NOP while stalled.
REQ-025 Address arithmetic SHALL be 12-bit modulo (0xFFF + 1 = 0x000); count registers SHALL be 14 bits (max 127*127).
REQ-026 An instruction presented while busy SHALL NOT be accepted; instr_valid_i is required to hold until accepted.

Reset
REQ-027 rst_i SHALL take effect at the next clk_i edge in any state, including mid-RUN/DRAIN, aborting the operation without a done_o pulse.
REQ-028 Reset values: state IDLE; instr_ready_o = 1 after reset; ub_rd_en_o, ub_wr_en_o, busy_o, done_o = 0; MAC_op_o = 3'b000; addresses = 0; delay line cleared; perf_cycles_o = 0.

Configuration
REQ-029 With macro MATMUL_SEQ_PERF_CNT_EN defined: perf_cycles_o counts non-stalled RUN+DRAIN cycles, saturates at 0xFFFF, and clears on handshake.
REQ-030 Without MATMUL_SEQ_PERF_CNT_EN: perf_cycles_o SHALL be constant 0, and no counter logic is synthesized.

Structure
REQ-031 tpu_package SHALL hold the state enum type seq_state_t, MAC_OP_NOP = 3'b000, and the default MAC_PIPE_LAT.
REQ-032 The write-valid delay is implemented by sub-module valid_delay_line (parameter DEPTH, inputs en and stall, output valid, plus an empty flag).

Verification
REQ-033 V=3, ITER=2, rd_start=0x010, wr_start=0x100, no stall -> reads 0x010..0x015 on 6 consecutive cycles; writes 0x100..0x105 starting 4 cycles after the first read; done_o pulses once.
REQ-034 V=0, ITER=5 -> no rd/wr enables; done_o one cycle after handshake; busy_o high for exactly 1 cycle.
REQ-035 rd_start=0xFFE, V=4, ITER=1 -> read addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-036 stall_i high for 3 cycles mid-RUN (V=4, ITER=1) -> enables low and addresses frozen for those cycles; sequence resumes with no missing or duplicate addresses; completion is 3 cycles later than the unstalled run.
REQ-037 rst_i asserted during DRAIN -> next cycle IDLE, all outputs at reset values, no done_o; a new instruction is then accepted normally.
REQ-038 instr_valid_i held during a busy operation -> not accepted until IDLE; accepted on the first IDLE cycle; with the macro defined, perf_cycles_o = 6+4 for the V=3, ITER=2 case.
